uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arbState_t     : arbiter FSM encoding (idle, launch pulse, wait for transmitter)
//   DefaultNumReq  : default number of requesters
//   DefaultTimeout : default watchdog limit in clk cycles
//   WdWidth        : watchdog counter width
//   wrapInc        : increment an index modulo n
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait
  } arbState_t;

  localparam int unsigned DefaultNumReq  = 4;
  localparam int unsigned DefaultTimeout = 32'd1 << 20;
  localparam int unsigned WdWidth        = 24;

  function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bundle of the UART transmit arbiter.
//   req_valid/req_data/req_last : per-requester byte offer (requester i owns data[8i+7:8i])
//   req_ready                   : one-cycle accept pulse back to the requester
//   tx_data/tx_valid/tx_done    : byte and start pulse to the UART, finished pulse back
//   grant_id/locked             : current owner and mid-message lock status
//   timeout_err/err_clr         : sticky watchdog flag and its clear
// Modport master is the requester/transmitter side, slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NumReq = uart_pkg::DefaultNumReq
);
  localparam int unsigned IdxW = $clog2(NumReq);

  logic [NumReq-1:0]   req_valid;
  logic [NumReq*8-1:0] req_data;
  logic [NumReq-1:0]   req_last;
  logic [NumReq-1:0]   req_ready;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_done;
  logic [IdxW-1:0]     grant_id;
  logic                locked;
  logic                timeout_err;
  logic                err_clr;

  modport master (
    output req_valid, req_data, req_last, tx_done, err_clr,
    input  req_ready, tx_data, tx_valid, grant_id, locked, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_done, err_clr,
    output req_ready, tx_data, tx_valid, grant_id, locked, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   valid  : request mask
//   start  : index with highest priority; priority falls with distance, wrapping
//   found  : at least one valid bit
//   winner : first valid index at or after start
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   start,
  output logic              found,
  output logic [IdxW-1:0]   winner
);

  localparam int unsigned SumW = IdxW + 1;

  logic [SumW-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      // start + i never exceeds 2*NumReq-2, so one conditional subtract wraps it
      idx = {1'b0, start} + SumW'(i);
      if (idx >= SumW'(NumReq)) begin
        idx = idx - SumW'(NumReq);
      end
      if (!found && valid[idx[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Multiplexes byte streams from NumReq requesters onto one UART transmitter.
// A requester owns the channel from its first byte until a byte flagged last has
// been transmitted; between owners the grant rotates round-robin. A watchdog
// releases the channel when the transmitter or the owner stalls.
//   clk    : system clock, rising edge
//   nReset : asynchronous active-low reset
//   bus    : requester/transmitter bundle (slave modport)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NumReq  = DefaultNumReq,
  parameter int unsigned Timeout = DefaultTimeout
) (
  input logic               clk,
  input logic               nReset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NumReq);

  arbState_t          stateQ, stateD;
  logic [7:0]         txDataQ, txDataD;
  logic [IdxW-1:0]    grantIdQ, grantIdD;
  logic [NumReq-1:0]  readyQ, readyD;
  logic               lastQ, lastD;
  logic               lockedQ, lockedD;
  logic [IdxW-1:0]    rrPtrQ, rrPtrD;
  logic [WdWidth-1:0] wdQ, wdD;
  logic               errQ, errD;

  logic [NumReq-1:0]  ownerMask;
  logic [NumReq-1:0]  eligible;
  logic [IdxW-1:0]    pickStart;
  logic               found;
  logic [IdxW-1:0]    winner;
  logic               wdInc;
  logic               wdFire;
  logic               errSet;
  logic [IdxW-1:0]    nextAfterOwner;

  // While locked only the owner may speak, so the mask collapses to its bit.
  assign ownerMask = NumReq'(1) << grantIdQ;
  assign eligible  = lockedQ ? (bus.req_valid & ownerMask) : bus.req_valid;
  assign pickStart = lockedQ ? grantIdQ : rrPtrQ;

  rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) uRrPick (
    .valid  (eligible),
    .start  (pickStart),
    .found  (found),
    .winner (winner)
  );

  assign nextAfterOwner = IdxW'(wrapInc(32'(grantIdQ), NumReq));

  // Count while waiting on the transmitter, or while a locked owner has gone quiet.
  assign wdInc  = (stateQ == StWait) ||
                  ((stateQ == StIdle) && lockedQ && !bus.req_valid[grantIdQ]);
  // Fires on the Timeout-th consecutive counting cycle.
  assign wdFire = wdInc && (wdQ == WdWidth'(Timeout - 1));

  always_comb begin
    stateD   = stateQ;
    txDataD  = txDataQ;
    grantIdD = grantIdQ;
    readyD   = '0;
    lastD    = lastQ;
    lockedD  = lockedQ;
    rrPtrD   = rrPtrQ;
    errSet   = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (found) begin
          txDataD        = bus.req_data[{winner, 3'b000} +: 8];
          grantIdD       = winner;
          readyD[winner] = 1'b1;
          lastD          = bus.req_last[winner];
          stateD         = StLaunch;
        end else if (wdFire) begin
          errSet  = 1'b1;
          lockedD = 1'b0;
          rrPtrD  = nextAfterOwner;
        end
      end
      StLaunch: begin
        stateD = StWait;
      end
      StWait: begin
        // A finished byte takes priority over a coincident watchdog expiry.
        if (bus.tx_done) begin
          stateD = StIdle;
          if (lastQ) begin
            lockedD = 1'b0;
            rrPtrD  = nextAfterOwner;
          end else begin
            lockedD = 1'b1;
          end
        end else if (wdFire) begin
          errSet  = 1'b1;
          lockedD = 1'b0;
          rrPtrD  = nextAfterOwner;
          stateD  = StIdle;
        end
      end
      default: begin
        stateD = StIdle;
      end
    endcase

    errD = errSet | (errQ & ~bus.err_clr);

    if ((stateD != stateQ) || errSet) begin
      wdD = '0;
    end else if (wdInc) begin
      wdD = wdQ + 1'b1;
    end else begin
      wdD = '0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stateQ   <= StIdle;
      txDataQ  <= '0;
      grantIdQ <= '0;
      readyQ   <= '0;
      lastQ    <= 1'b0;
      lockedQ  <= 1'b0;
      rrPtrQ   <= '0;
      wdQ      <= '0;
      errQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      txDataQ  <= txDataD;
      grantIdQ <= grantIdD;
      readyQ   <= readyD;
      lastQ    <= lastD;
      lockedQ  <= lockedD;
      rrPtrQ   <= rrPtrD;
      wdQ      <= wdD;
      errQ     <= errD;
    end
  end

  assign bus.tx_valid    = (stateQ == StLaunch);
  assign bus.tx_data     = txDataQ;
  assign bus.req_ready   = readyQ;
  assign bus.grant_id    = grantIdQ;
  assign bus.locked      = lockedQ;
  assign bus.timeout_err = errQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq  = 4;
  localparam int unsigned Timeout = 16;

  logic clk = 1'b0;
  logic nReset;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NumReq(NumReq)) bus ();

  uart_tx_arbiter #(
    .NumReq  (NumReq),
    .Timeout (Timeout)
  ) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  int nChecks = 0;
  int nPass   = 0;

  // Random-test stimulus queues: pending bytes and last flags per requester.
  logic [7:0] qd [NumReq][$];
  bit         ql [NumReq][$];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
    bus.err_clr   = 1'b0;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input bit last);
    bus.req_valid[i]      = 1'b1;
    bus.req_data[8*i +: 8] = d;
    bus.req_last[i]       = last;
  endtask

  // Called at the launch-cycle negedge; raises tx_done in the d-th wait cycle.
  task automatic finish_byte(input int d);
    repeat (d) @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  task automatic check_launch(input string name, input int id, input logic [7:0] d);
    nChecks++;
    if (bus.tx_valid !== 1'b1) $display("FAIL %s_valid: tx_valid=%b want 1", name, bus.tx_valid);
    else nPass++;
    nChecks++;
    if (bus.grant_id !== 2'(id)) $display("FAIL %s_grant: got %0d want %0d", name, bus.grant_id, id);
    else nPass++;
    nChecks++;
    if (bus.tx_data !== d) $display("FAIL %s_data: got %h want %h", name, bus.tx_data, d);
    else nPass++;
    nChecks++;
    if (bus.req_ready !== (4'b0001 << id))
      $display("FAIL %s_ready: got %b want %b", name, bus.req_ready, 4'b0001 << id);
    else nPass++;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    clear_inputs();
    @(negedge clk);
    nChecks++;
    if (bus.tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid);
    else nPass++;
    nChecks++;
    if (bus.req_ready !== 4'b0) $display("FAIL rst_ready: got %b want 0", bus.req_ready);
    else nPass++;
    nChecks++;
    if (bus.tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", bus.tx_data);
    else nPass++;
    nChecks++;
    if (bus.grant_id !== 2'd0) $display("FAIL rst_grant: got %0d want 0", bus.grant_id);
    else nPass++;
    nChecks++;
    if (bus.locked !== 1'b0) $display("FAIL rst_locked: got %b want 0", bus.locked);
    else nPass++;
    nChecks++;
    if (bus.timeout_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.timeout_err);
    else nPass++;
  endtask

  task automatic test_single_byte();
    do_reset();
    set_req(2, 8'h5A, 1'b1);
    @(negedge clk);
    check_launch("single", 2, 8'h5A);
    clear_inputs();
    @(negedge clk);
    nChecks++;
    if (bus.tx_valid !== 1'b0 || bus.req_ready !== 4'b0)
      $display("FAIL single_pulse: tx_valid=%b ready=%b want 0/0", bus.tx_valid, bus.req_ready);
    else nPass++;
    finish_byte(8);
    nChecks++;
    if (bus.locked !== 1'b0) $display("FAIL single_unlock: got %b want 0", bus.locked);
    else nPass++;
    // Pointer should now sit at 3: offer everyone and see who wins.
    for (int i = 0; i < NumReq; i++) set_req(i, 8'hC0 + 8'(i), 1'b1);
    @(negedge clk);
    check_launch("single_rrptr", 3, 8'hC3);
    clear_inputs();
    finish_byte(1);
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NumReq; i++) set_req(i, 8'hA0 + 8'(i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_launch("fair", k % NumReq, 8'hA0 + 8'(k % NumReq));
      finish_byte(2);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_lock();
    do_reset();
    set_req(1, 8'h11, 1'b0);
    @(negedge clk);
    check_launch("lock_first", 1, 8'h11);
    set_req(1, 8'h22, 1'b1);
    set_req(0, 8'h33, 1'b1);
    finish_byte(3);
    nChecks++;
    if (bus.locked !== 1'b1) $display("FAIL lock_held: got %b want 1", bus.locked);
    else nPass++;
    @(negedge clk);
    check_launch("lock_second", 1, 8'h22);
    bus.req_valid[1] = 1'b0;
    finish_byte(2);
    nChecks++;
    if (bus.locked !== 1'b0) $display("FAIL lock_release: got %b want 0", bus.locked);
    else nPass++;
    @(negedge clk);
    check_launch("lock_next_owner", 0, 8'h33);
    clear_inputs();
    finish_byte(1);
  endtask

  task automatic test_ignore();
    bit seen;
    do_reset();
    bus.tx_done = 1'b1;
    @(negedge clk);
    set_req(2, 8'h5A, 1'b1);
    @(negedge clk);
    check_launch("ign_launch", 2, 8'h5A);
    // tx_done held into the launch cycle, requester swapped while busy
    bus.req_valid = '0;
    set_req(3, 8'h77, 1'b1);
    @(negedge clk);
    bus.tx_done = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b0) seen = 1'b1;
    end
    nChecks++;
    if (seen) $display("FAIL ign_spurious_done: tx_valid seen=1 want 0");
    else nPass++;
    finish_byte(0);
    @(negedge clk);
    check_launch("ign_after", 3, 8'h77);
    clear_inputs();
    finish_byte(1);
  endtask

  task automatic test_coincident();
    do_reset();
    set_req(0, 8'h01, 1'b1);
    @(negedge clk);
    check_launch("coin_launch", 0, 8'h01);
    clear_inputs();
    finish_byte(Timeout);
    nChecks++;
    if (bus.timeout_err !== 1'b0) $display("FAIL coin_err: got %b want 0", bus.timeout_err);
    else nPass++;
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(1, 8'h77, 1'b1);
    @(negedge clk);
    check_launch("to_launch", 1, 8'h77);
    clear_inputs();
    repeat (Timeout) @(negedge clk);
    nChecks++;
    if (bus.timeout_err !== 1'b0) $display("FAIL to_early: got %b want 0", bus.timeout_err);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if (bus.timeout_err !== 1'b1) $display("FAIL to_set: got %b want 1", bus.timeout_err);
    else nPass++;
    for (int i = 0; i < NumReq; i++) set_req(i, 8'h90 + 8'(i), 1'b1);
    @(negedge clk);
    check_launch("to_next", 2, 8'h92);
    clear_inputs();
    finish_byte(1);
    nChecks++;
    if (bus.timeout_err !== 1'b1) $display("FAIL to_sticky: got %b want 1", bus.timeout_err);
    else nPass++;
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    nChecks++;
    if (bus.timeout_err !== 1'b0) $display("FAIL to_clear: got %b want 0", bus.timeout_err);
    else nPass++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_req(2, 8'h40, 1'b0);
    @(negedge clk);
    check_launch("rmw_first", 2, 8'h40);
    set_req(2, 8'h41, 1'b0);
    finish_byte(2);
    @(negedge clk);
    check_launch("rmw_second", 2, 8'h41);
    clear_inputs();
    @(negedge clk);
    nChecks++;
    if (bus.locked !== 1'b1) $display("FAIL rmw_prelock: got %b want 1", bus.locked);
    else nPass++;
    nReset = 1'b0;
    #1;
    nChecks++;
    if (bus.locked !== 1'b0 || bus.tx_valid !== 1'b0 || bus.grant_id !== 2'd0)
      $display("FAIL rmw_async: locked=%b tx_valid=%b grant=%0d want 0/0/0",
               bus.locked, bus.tx_valid, bus.grant_id);
    else nPass++;
    @(negedge clk);
    nReset = 1'b1;
    set_req(3, 8'h99, 1'b1);
    @(negedge clk);
    check_launch("rmw_after", 3, 8'h99);
    clear_inputs();
    finish_byte(1);
  endtask

  task automatic drive_heads();
    for (int i = 0; i < NumReq; i++) begin
      if (qd[i].size() > 0) begin
        set_req(i, qd[i][0], ql[i][0]);
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
  endtask

  // Transaction-level model: owner/lock/pointer advanced per completed byte.
  task automatic test_random();
    int  mRr, mOwner, expW, cnt, expCnt, len, total;
    bit  mLocked, busy, curLast, expFlag, finished;
    do_reset();
    total = 0;
    for (int i = 0; i < NumReq; i++) begin
      qd[i].delete();
      ql[i].delete();
      for (int m = 0; m < int'($urandom_range(0, 3)); m++) begin
        len = int'($urandom_range(1, 3));
        for (int b = 0; b < len; b++) begin
          qd[i].push_back(8'($urandom));
          ql[i].push_back(b == len - 1);
          total++;
        end
      end
    end
    mRr = 0; mOwner = 0; mLocked = 0; busy = 0; cnt = 0;
    expCnt = 0; expFlag = 0; curLast = 0; finished = 0;
    drive_heads();
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (expCnt > 0) begin
        expCnt--;
        if (expCnt == 0) begin
          nChecks++;
          if (bus.tx_valid !== expFlag)
            $display("FAIL rand_b2b: tx_valid=%b want %b", bus.tx_valid, expFlag);
          else nPass++;
        end
      end
      if (bus.tx_valid === 1'b1) begin
        expW = -1;
        if (mLocked) expW = mOwner;
        else begin
          for (int k = 0; k < NumReq; k++) begin
            if (expW < 0 && qd[(mRr + k) % NumReq].size() > 0) expW = (mRr + k) % NumReq;
          end
        end
        nChecks++;
        if (busy || expW < 0) begin
          $display("FAIL rand_unexpected: launch while busy=%b eligible=%0d", busy, expW);
        end else begin
          nPass++;
          check_launch("rand", expW, qd[expW][0]);
          curLast = ql[expW][0];
          void'(qd[expW].pop_front());
          void'(ql[expW].pop_front());
          mOwner = expW;
          busy   = 1'b1;
          cnt    = int'($urandom_range(1, 8));
        end
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          bus.tx_done = 1'b1;
          busy        = 1'b0;
          if (curLast) begin
            mLocked = 1'b0;
            mRr     = (mOwner + 1) % NumReq;
          end else begin
            mLocked = 1'b1;
          end
          expFlag = mLocked;
          for (int i = 0; i < NumReq; i++) if (qd[i].size() > 0) expFlag = 1'b1;
          expCnt = 2;
        end
      end
      drive_heads();
      if (!busy && expCnt == 0 && bus.req_valid == '0 && bus.tx_valid !== 1'b1) finished = 1'b1;
    end
    nChecks++;
    if (!finished) $display("FAIL rand_budget: %0d bytes offered, run did not drain", total);
    else nPass++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fairness();
    test_lock();
    test_ignore();
    test_coincident();
    test_timeout();
    test_reset_mid_wait();
    for (int r = 0; r < 4; r++) test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
